br_tx_queue: RTL and testbench
==============================

Name: br_tx_queue

Overview:
- Local-side injection stage for a BrLite broadcast port; sits directly upstream of the router port that the broadcast traffic logger monitors.
- Buffers broadcast packets from the local PE in a FIFO and presents them to the router with a tx/ack handshake.
- Per-packet instrumentation: head wait cycles, stall flag, enqueue-to-accept latency, overflow drop count.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- WAIT_W, 16, width of the head wait counter.
- STALL_LIMIT, 8, head wait-cycle threshold that asserts stall_o.
- LAT_W, 32, width of timestamps and latency.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  1  PE enqueue request.
- data_i  in  br_data_t  packet to enqueue.
- ready_o  out  1  FIFO can accept (count < DEPTH).
- tx_o  out  1  packet valid toward router.
- ack_tx_i  in  1  router accepts head this cycle.
- data_o  out  br_data_t  head packet.
- tick_cntr_i  in  64  global tick counter; low LAT_W bits used.
- wait_cntr_o  out  WAIT_W  cycles the current head has waited.
- stall_o  out  1  wait_cntr_o >= STALL_LIMIT.
- lat_valid_o  out  1  one-cycle pulse per accepted packet.
- lat_o  out  LAT_W  latency of the last accepted packet.
- drop_cntr_o  out  16  saturating count of rejected requests.

Behaviour:
- Reset (rst_i high at a clock edge):
  - count, pointers, wait_cntr_o, drop_cntr_o, lat_o, lat_valid_o, stall_o all 0.
  - ready_o is 1 and tx_o is 0 out of reset.
  - FIFO storage is not cleared.
  - Reset mid-transfer discards all queued packets; no handshake completes on the reset edge.
- Enqueue:
  - Push when req_i && ready_o.
  - Each entry stores data_i plus stamp = tick_cntr_i[LAT_W-1:0] sampled in the push cycle.
- Full:
  - ready_o derives from the registered count only; no combinational path from ack_tx_i.
  - At count == DEPTH a simultaneous pop does not enable a push.
  - req_i while ready_o == 0 is dropped and drop_cntr_o increments by 1, saturating at 16'hFFFF.
- Output:
  - tx_o = (count != 0). data_o = head entry.
  - data_o is don't-care while tx_o is 0.
  - A push into an empty FIFO at edge N makes tx_o high after edge N (no same-cycle bypass).
- Handshake:
  - Transfer occurs when tx_o && ack_tx_i in the same cycle; the head pops at that edge.
  - ack_tx_i with tx_o low is ignored.
  - tx_o and data_o stay stable until accepted.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Wait counter:
  - Each cycle with tx_o && !ack_tx_i: wait_cntr_o increments, saturating at all-ones.
  - Reset to 0 on transfer.
  - 0 while empty.
  - The next head starts at 0.
- stall_o:
  - Registered; at each edge takes (next wait_cntr value >= STALL_LIMIT), so it tracks wait_cntr_o with no extra lag.
  - Clears on the edge of the transfer.
- Latency:
  - On a transfer edge, lat_o <= tick_cntr_i[LAT_W-1:0] - head stamp, modulo 2^LAT_W (tick wrap tolerated).
  - lat_valid_o is high for exactly the following cycle; otherwise 0.
  - lat_o holds its value between transfers.
- No state machine beyond FIFO occupancy: EMPTY (count 0), PARTIAL, FULL (count DEPTH); transitions follow push/pop above.

Test Plan:
1. Reset, then push A at tick 100 with ack_tx_i tied high -> tx_o high the next cycle with data_o = A; transfer that cycle; lat_valid_o pulses with lat_o = 1; wait_cntr_o stays 0.
2. Push 4 packets back-to-back with ack_tx_i low -> ready_o low after the 4th push; a 5th req_i sets drop_cntr_o = 1; head order is preserved on later acks.
3. Hold the head 10 cycles with no ack -> wait_cntr_o reaches 10; stall_o rises when wait_cntr_o reaches 8; on ack, both clear and the next head starts at 0.
4. count = 2, push and ack in the same cycle -> count stays 2; FIFO order is correct across pointer wrap over 3 full cycles of DEPTH.
5. Stamp taken at tick 32'hFFFF_FFFE, accepted at tick 32'h0000_0003 -> lat_o = 5.
6. Assert rst_i while count = 3 and tx_o high -> tx_o = 0, ready_o = 1, counters 0 the next cycle; no lat_valid_o pulse.

Source files
------------

// File: rtl/br_tx_queue.sv
// BrLite broadcast injection queue: buffers local PE packets, drives the router tx/ack
// handshake and reports per-packet head wait, stall, latency and overflow drops.
package br_tx_queue_pkg;
  typedef struct packed {
    logic [7:0]  src;
    logic [7:0]  service;
    logic [15:0] payload;
  } br_data_t;
endpackage

module br_tx_queue
  import br_tx_queue_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned WAIT_W      = 16,
  parameter int unsigned STALL_LIMIT = 8,
  parameter int unsigned LAT_W       = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  br_data_t          data_i,
  output logic              ready_o,
  output logic              tx_o,
  input  logic              ack_tx_i,
  output br_data_t          data_o,
  input  logic [63:0]       tick_cntr_i,
  output logic [WAIT_W-1:0] wait_cntr_o,
  output logic              stall_o,
  output logic              lat_valid_o,
  output logic [LAT_W-1:0]  lat_o,
  output logic [15:0]       drop_cntr_o
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned DROP_W = 16;

  br_data_t         data_mem_q  [DEPTH];
  logic [LAT_W-1:0] stamp_mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ready_q, ready_d;
  logic              tx_q, tx_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              stall_q, stall_d;
  logic              lat_valid_q, lat_valid_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              push;
  logic              pop;
  logic              unused_tick;

  // Only the low LAT_W tick bits feed the timestamps.
  assign unused_tick = ^tick_cntr_i;

  // Next-state for occupancy, pointers and instrumentation.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    ready_d     = ready_q;
    tx_d        = tx_q;
    wait_d      = wait_q;
    stall_d     = stall_q;
    lat_valid_d = 1'b0;
    lat_d       = lat_q;
    drop_d      = drop_q;

    // ready_q/tx_q are registered, so a pop never opens room for a same-cycle push.
    push = req_i && ready_q;
    pop  = tx_q && ack_tx_i;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    ready_d = (count_d != CNT_W'(DEPTH));
    tx_d    = (count_d != CNT_W'(0));

    if (pop) begin
      wait_d = '0;
    end else if (tx_q && (wait_q != '1)) begin
      wait_d = wait_q + WAIT_W'(1);
    end
    stall_d = (wait_d >= WAIT_W'(STALL_LIMIT));

    if (pop) begin
      lat_valid_d = 1'b1;
      lat_d       = tick_cntr_i[LAT_W-1:0] - stamp_mem_q[rd_ptr_q];
    end

    if (req_i && !ready_q && (drop_q != '1)) begin
      drop_d = drop_q + DROP_W'(1);
    end
  end

  // Control and counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ready_q     <= 1'b1;
      tx_q        <= 1'b0;
      wait_q      <= '0;
      stall_q     <= 1'b0;
      lat_valid_q <= 1'b0;
      lat_q       <= '0;
      drop_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ready_q     <= ready_d;
      tx_q        <= tx_d;
      wait_q      <= wait_d;
      stall_q     <= stall_d;
      lat_valid_q <= lat_valid_d;
      lat_q       <= lat_d;
      drop_q      <= drop_d;
    end
  end

  // Packet storage; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      data_mem_q[wr_ptr_q]  <= data_i;
      stamp_mem_q[wr_ptr_q] <= tick_cntr_i[LAT_W-1:0];
    end
  end

  assign ready_o     = ready_q;
  assign tx_o        = tx_q;
  assign data_o      = data_mem_q[rd_ptr_q];
  assign wait_cntr_o = wait_q;
  assign stall_o     = stall_q;
  assign lat_valid_o = lat_valid_q;
  assign lat_o       = lat_q;
  assign drop_cntr_o = drop_q;

endmodule

// File: tb/tb_br_tx_queue.sv
// Self-checking bench for br_tx_queue: directed vector table, hand sequences for the
// multi-cycle corners, and randomized traffic against a queue-based reference model.
module tb_br_tx_queue;
  import br_tx_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int STALL = 8;

  bit          clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  br_data_t    data_i = '0;
  logic        ready_o;
  logic        tx_o;
  logic        ack_tx_i = 1'b0;
  br_data_t    data_o;
  logic [63:0] tick_cntr_i = '0;
  logic [15:0] wait_cntr_o;
  logic        stall_o;
  logic        lat_valid_o;
  logic [31:0] lat_o;
  logic [15:0] drop_cntr_o;

  always #5 clk = ~clk;

  br_tx_queue dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .data_i      (data_i),
    .ready_o     (ready_o),
    .tx_o        (tx_o),
    .ack_tx_i    (ack_tx_i),
    .data_o      (data_o),
    .tick_cntr_i (tick_cntr_i),
    .wait_cntr_o (wait_cntr_o),
    .stall_o     (stall_o),
    .lat_valid_o (lat_valid_o),
    .lat_o       (lat_o),
    .drop_cntr_o (drop_cntr_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a packet queue plus plain integer counters.
  typedef struct { br_data_t d; logic [31:0] st; } ent_t;
  ent_t        m_q[$];
  int          m_wait;
  int          m_drop;
  bit          m_stall;
  bit          m_lv;
  logic [31:0] m_lat;
  logic [63:0] g_tick;

  function automatic br_data_t pkt(input logic [15:0] tag);
    br_data_t p;
    p.src     = 8'h11 ^ tag[7:0];
    p.service = 8'h22;
    p.payload = tag;
    return p;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit req, input bit ack,
                            input br_data_t d, input logic [63:0] tick);
    bit m_ready, m_tx, push, pop;
    if (rst) begin
      m_q.delete();
      m_wait = 0; m_drop = 0; m_stall = 0; m_lv = 0; m_lat = '0;
      return;
    end
    m_ready = (m_q.size() < DEPTH);
    m_tx    = (m_q.size() != 0);
    pop     = m_tx && ack;
    push    = req && m_ready;
    m_lv    = pop;
    if (pop) begin
      m_lat  = tick[31:0] - m_q[0].st;
      void'(m_q.pop_front());
      m_wait = 0;
    end else if (m_tx && m_wait < 65535) begin
      m_wait++;
    end
    if (push) m_q.push_back('{d: d, st: tick[31:0]});
    if (req && !m_ready && m_drop < 65535) m_drop++;
    m_stall = (m_wait >= STALL);
  endtask

  task automatic check_all();
    chk("tx_o", 64'(tx_o), 64'(m_q.size() != 0));
    chk("ready_o", 64'(ready_o), 64'(m_q.size() < DEPTH));
    if (m_q.size() != 0) chk("data_o", 64'(data_o), 64'(m_q[0].d));
    chk("wait_cntr_o", 64'(wait_cntr_o), 64'(m_wait));
    chk("stall_o", 64'(stall_o), 64'(m_stall));
    chk("drop_cntr_o", 64'(drop_cntr_o), 64'(m_drop));
    chk("lat_valid_o", 64'(lat_valid_o), 64'(m_lv));
    chk("lat_o", 64'(lat_o), 64'(m_lat));
  endtask

  // One clock: drive inputs, advance the model, check outputs 1ns after the edge.
  task automatic cyc(input bit rst, input bit req, input bit ack,
                     input br_data_t d, input logic [63:0] tick);
    rst_i = rst; req_i = req; ack_tx_i = ack; data_i = d; tick_cntr_i = tick;
    model_step(rst, req, ack, d, tick);
    @(posedge clk);
    #1;
    check_all();
  endtask

  typedef struct {
    bit          req;
    bit          ack;
    logic [15:0] tag;
    logic [63:0] tick;
    bit          e_tx;
    bit          e_ready;
    logic [15:0] e_tag;
    int          e_wait;
    int          e_drop;
    bit          e_lv;
    logic [31:0] e_lat;
  } vec_t;

  vec_t tbl[12];
  int   ack_pct;

  initial begin
    // Single push with ack held high, then fill to full, drop, and drain in order.
    tbl[0]  = '{1, 1, 16'h000A, 64'd100, 1, 1, 16'h000A, 0, 0, 0, 32'd0};
    tbl[1]  = '{0, 1, 16'h0000, 64'd101, 0, 1, 16'h0000, 0, 0, 1, 32'd1};
    tbl[2]  = '{0, 0, 16'h0000, 64'd102, 0, 1, 16'h0000, 0, 0, 0, 32'd1};
    tbl[3]  = '{1, 0, 16'h000B, 64'd103, 1, 1, 16'h000B, 0, 0, 0, 32'd1};
    tbl[4]  = '{1, 0, 16'h000C, 64'd104, 1, 1, 16'h000B, 1, 0, 0, 32'd1};
    tbl[5]  = '{1, 0, 16'h000D, 64'd105, 1, 1, 16'h000B, 2, 0, 0, 32'd1};
    tbl[6]  = '{1, 0, 16'h000E, 64'd106, 1, 0, 16'h000B, 3, 0, 0, 32'd1};
    tbl[7]  = '{1, 0, 16'h000F, 64'd107, 1, 0, 16'h000B, 4, 1, 0, 32'd1};
    tbl[8]  = '{1, 1, 16'h0006, 64'd108, 1, 1, 16'h000C, 0, 2, 1, 32'd5};
    tbl[9]  = '{0, 1, 16'h0000, 64'd109, 1, 1, 16'h000D, 0, 2, 1, 32'd5};
    tbl[10] = '{0, 1, 16'h0000, 64'd110, 1, 1, 16'h000E, 0, 2, 1, 32'd5};
    tbl[11] = '{0, 1, 16'h0000, 64'd111, 0, 1, 16'h0000, 0, 2, 1, 32'd5};

    m_wait = 0; m_drop = 0; m_stall = 0; m_lv = 0; m_lat = '0;

    cyc(1, 0, 0, pkt(0), 64'd98);
    cyc(1, 1, 1, pkt(1), 64'd99);
    chk("rst tx_o", 64'(tx_o), 64'd0);
    chk("rst ready_o", 64'(ready_o), 64'd1);
    chk("rst drop", 64'(drop_cntr_o), 64'd0);
    chk("rst lat_valid", 64'(lat_valid_o), 64'd0);

    for (int i = 0; i < 12; i++) begin
      cyc(0, tbl[i].req, tbl[i].ack, pkt(tbl[i].tag), tbl[i].tick);
      chk($sformatf("vec%0d tx", i), 64'(tx_o), 64'(tbl[i].e_tx));
      chk($sformatf("vec%0d ready", i), 64'(ready_o), 64'(tbl[i].e_ready));
      if (tbl[i].e_tx) chk($sformatf("vec%0d data", i), 64'(data_o), 64'(pkt(tbl[i].e_tag)));
      chk($sformatf("vec%0d wait", i), 64'(wait_cntr_o), 64'(tbl[i].e_wait));
      chk($sformatf("vec%0d drop", i), 64'(drop_cntr_o), 64'(tbl[i].e_drop));
      chk($sformatf("vec%0d lv", i), 64'(lat_valid_o), 64'(tbl[i].e_lv));
      chk($sformatf("vec%0d lat", i), 64'(lat_o), 64'(tbl[i].e_lat));
    end
    g_tick = 64'd200;

    // Head held without ack: wait climbs, stall rises at the limit, both clear on accept.
    cyc(0, 1, 0, pkt(16'h0030), g_tick++);
    cyc(0, 1, 0, pkt(16'h0031), g_tick++);
    for (int i = 0; i < 9; i++) begin
      cyc(0, 0, 0, pkt(0), g_tick++);
      chk("hold wait", 64'(wait_cntr_o), 64'(i + 2));
      chk("hold stall", 64'(stall_o), 64'((i + 2) >= STALL));
    end
    cyc(0, 0, 1, pkt(0), g_tick++);
    chk("accept wait", 64'(wait_cntr_o), 64'd0);
    chk("accept stall", 64'(stall_o), 64'd0);
    chk("next head", 64'(data_o), 64'(pkt(16'h0031)));
    cyc(0, 0, 1, pkt(0), g_tick++);

    // Steady push+pop at count 2 across several pointer wraps.
    cyc(0, 1, 0, pkt(16'h0040), g_tick++);
    cyc(0, 1, 0, pkt(16'h0041), g_tick++);
    for (int k = 0; k < 3 * DEPTH; k++) begin
      cyc(0, 1, 1, pkt(16'(16'h0042 + k)), g_tick++);
      chk("wrap tx", 64'(tx_o), 64'd1);
      chk("wrap ready", 64'(ready_o), 64'd1);
      chk("wrap head", 64'(data_o), 64'(pkt(16'(16'h0041 + k))));
    end
    cyc(0, 0, 1, pkt(0), g_tick++);
    cyc(0, 0, 1, pkt(0), g_tick++);

    // Latency across a 32-bit tick wrap.
    cyc(0, 1, 0, pkt(16'h0050), 64'hABCD_0000_FFFF_FFFE);
    cyc(0, 0, 0, pkt(0), 64'hABCD_0000_FFFF_FFFF);
    cyc(0, 0, 0, pkt(0), 64'hABCD_0001_0000_0000);
    cyc(0, 0, 0, pkt(0), 64'hABCD_0001_0000_0001);
    cyc(0, 0, 0, pkt(0), 64'hABCD_0001_0000_0002);
    cyc(0, 0, 1, pkt(0), 64'hABCD_0001_0000_0003);
    chk("wrap lat", 64'(lat_o), 64'd5);
    chk("wrap lat_valid", 64'(lat_valid_o), 64'd1);

    // Reset with three queued packets and an ack pending.
    cyc(0, 1, 0, pkt(16'h0060), g_tick++);
    cyc(0, 1, 0, pkt(16'h0061), g_tick++);
    cyc(0, 1, 0, pkt(16'h0062), g_tick++);
    cyc(1, 1, 1, pkt(16'h0063), g_tick++);
    chk("midrst tx", 64'(tx_o), 64'd0);
    chk("midrst ready", 64'(ready_o), 64'd1);
    chk("midrst wait", 64'(wait_cntr_o), 64'd0);
    chk("midrst drop", 64'(drop_cntr_o), 64'd0);
    chk("midrst lv", 64'(lat_valid_o), 64'd0);
    cyc(0, 0, 0, pkt(0), g_tick++);
    chk("postrst lv", 64'(lat_valid_o), 64'd0);
    chk("postrst tx", 64'(tx_o), 64'd0);

    // Randomized traffic with alternating back-pressure phases.
    for (int ph = 0; ph < 6; ph++) begin
      ack_pct = (ph % 2 == 0) ? 15 : 85;
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(0, 63) == 0) g_tick = {32'($urandom), 32'hFFFF_FFF0};
        g_tick = g_tick + 64'($urandom_range(1, 3));
        cyc(($urandom_range(0, 249) == 0),
            ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 99) < ack_pct),
            pkt(16'($urandom)), g_tick);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
